// File: rtl/adder_arb_pkg.sv
//----------------------------------------------------------------------------
// Module  : adder_arb_pkg
// Brief   : Shared constants, state encoding and helpers for adder_arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package adder_arb_pkg;

  // Default build configuration
  localparam int DEF_NREQ   = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_SETTLE = 2;

  // Arbiter FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  // Width of a requester id; never narrower than one bit
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder.sv
//----------------------------------------------------------------------------
// Module  : adder
// Brief   : Plain combinational ripple-carry adder shared by adder_arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;
  assign c_out    = carry[WIDTH];

  // One full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
//----------------------------------------------------------------------------
// Module  : adder_arbiter
// Brief   : Round-robin sharing of one ripple adder between NREQ requesters.
//           Granted operands are registered into the adder, the block waits
//           SETTLE cycles, then returns the id-tagged result.
//           Optional: ADDER_ARB_SAT_EN makes the sum saturate on carry out.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*WIDTH-1:0]        req_a,
  input  logic [NREQ*WIDTH-1:0]        req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [id_width(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]             rsp_sum,
  output logic                         rsp_c_out
);

  localparam int             IDW      = id_width(NREQ);
  localparam int             CW       = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_c_out_q, rsp_c_out_d;

  logic [IDW:0]     pick;
  logic             grant;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_c_out;
  logic [WIDTH-1:0] res_sum;

  // First valid requester at or after p, wrapping; MSB flags a hit
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  p);
    logic [IDW:0]   r;
    logic [IDW-1:0] cand;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(p) + k) % NREQ);
      if (v[cand]) r = {1'b1, cand};
    end
    return r;
  endfunction

  // The block is the sole driver of the shared adder's inputs
  adder #(.WIDTH(WIDTH)) u_adder (
    .a     (a_q),
    .b     (b_q),
    .sum   (add_sum),
    .c_out (add_c_out)
  );

  // Round-robin search; a grant is only offered while idle
  always_comb begin
    pick    = rr_pick(req_valid, ptr_q);
    gnt_idx = pick[IDW-1:0];
    grant   = (state_q == ST_IDLE) && pick[IDW];
  end

  // One-hot ready and operand mux for the winning requester
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
      req_ready[i] = grant && (gnt_idx == IDW'(i));
    end
  end

  // Result shaping: wrap by default, clamp to all-ones when saturating
  always_comb begin
`ifdef ADDER_ARB_SAT_EN
    res_sum = add_c_out ? '1 : add_sum;
`else
    res_sum = add_sum;
`endif
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_c_out_d = rsp_c_out_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = gnt_idx;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Operands have been stable for SETTLE cycles once the count hits 1
        if (cnt_q == CNT_ONE) begin
          rsp_sum_d   = res_sum;
          rsp_c_out_d = add_c_out;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_sum_q   <= '0;
      rsp_c_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_c_out_q <= rsp_c_out_d;
    end
  end

  // Response channel outputs
  always_comb begin
    rsp_valid = (state_q == ST_RESP);
    rsp_id    = id_q;
    rsp_sum   = rsp_sum_q;
    rsp_c_out = rsp_c_out_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
//----------------------------------------------------------------------------
// Module  : tb_adder_arbiter
// Brief   : Self-checking bench for adder_arbiter against a cycle-count
//           transaction model (grant time, response time, a+b arithmetic).
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_adder_arbiter;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 16;
  localparam int SETTLE = 2;
  localparam int IDW    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a, req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [WIDTH-1:0]        rsp_sum;
  logic                    rsp_c_out;

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_c_out (rsp_c_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester-side state: each holds valid and operands until accepted
  bit              vld [NREQ];
  logic [15:0]     opa [NREQ];
  logic [15:0]     opb [NREQ];

  // Transaction model
  bit          m_busy = 0;
  int          m_rsp_cyc = 0;
  int          m_id = 0;
  int          m_ptr = 0;
  logic [16:0] m_val = '0;
  int          cyc = 0;
  int          rsp_ids[$];
  int          rsp_cycs[$];

  function automatic logic [16:0] shape(input logic [16:0] full);
`ifdef ADDER_ARB_SAT_EN
    if (full[16]) return 17'h1FFFF;
`endif
    return full;
  endfunction

  function automatic int pick_model();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (vld[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = vld[i];
      req_a[i*WIDTH +: WIDTH] = opa[i];
      req_b[i*WIDTH +: WIDTH] = opb[i];
    end
  endtask

  // One clock: check at negedge, advance the model at posedge
  task automatic step();
    int              g;
    bit              rsp_now;
    logic [NREQ-1:0] exp_rdy;
    drive();
    @(negedge clk);
    g       = m_busy ? -1 : pick_model();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rsp_now = m_busy && (cyc >= m_rsp_cyc);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(rsp_now));
    if (rsp_now) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_result", 32'({rsp_c_out, rsp_sum}), 32'(shape(m_val)));
    end
    @(posedge clk);
    if (rst) begin
      m_busy = 0;
      m_ptr  = 0;
    end else if (g >= 0) begin
      m_busy    = 1;
      m_id      = g;
      m_rsp_cyc = cyc + SETTLE + 1;
      m_val     = {1'b0, opa[g]} + {1'b0, opb[g]};
      vld[g]    = 0;
    end else if (rsp_now && rsp_ready) begin
      rsp_ids.push_back(m_id);
      rsp_cycs.push_back(cyc);
      m_busy = 0;
      m_ptr  = (m_id + 1) % NREQ;
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_busy && guard < 20) begin
      step();
      guard++;
    end
    if (m_busy) check("drain_timeout", 32'd1, 32'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 16'(65535 - $urandom_range(0, 15));
      1:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  int sweep_vals[$];

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 0; opa[i] = '0; opb[i] = '0;
    end
    rst = 1'b1; rsp_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset_rsp_c_out", 32'(rsp_c_out), 32'd0);
    @(posedge clk); #1; cyc++;

    // Requester 0: 1 + 2
    vld[0] = 1; opa[0] = 16'h0001; opb[0] = 16'h0002;
    step(); drain();
    // Requester 2: wrap / saturate case
    vld[2] = 1; opa[2] = 16'hFFFF; opb[2] = 16'h0001;
    step(); drain();

    // Consumer stalls 5 cycles in RESP while others wait
    rsp_ready = 1'b0;
    vld[1] = 1; opa[1] = 16'h1234; opb[1] = 16'h4321;
    step();
    vld[3] = 1; opa[3] = 16'h00AA; opb[3] = 16'h0055;
    repeat (SETTLE + 5) step();
    rsp_ready = 1'b1;
    step(); step(); drain();

    // All four valid from reset, held: ids 0,1,2,3,0 every SETTLE+2 cycles
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1; opa[i] = 16'(16'h1000 * (i + 1)); opb[i] = 16'(i + 7);
    end
    rsp_ids.delete(); rsp_cycs.delete();
    repeat (22) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (!vld[i]) begin vld[i] = 1; opa[i] = rnd_op(); opb[i] = rnd_op(); end
    end
    check("rr_count", 32'(rsp_ids.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < rsp_ids.size(); k++) begin
      check("rr_id_seq", 32'(rsp_ids[k]), 32'(k % NREQ));
      if (k > 0) check("rr_spacing", 32'(rsp_cycs[k] - rsp_cycs[k-1]), 32'(SETTLE + 2));
    end
    for (int i = 0; i < NREQ; i++) vld[i] = 0;
    drain();

    // Reset in the second SETTLE cycle drops the in-flight operation
    vld[1] = 1; opa[1] = 16'h0101; opb[1] = 16'h0202;
    vld[3] = 1; opa[3] = 16'h0303; opb[3] = 16'h0404;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_sum", 32'({rsp_c_out, rsp_sum}), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    vld[1] = 1; vld[3] = 1;
    step(); drain();
    step(); drain();

    // Sweep through requester 1
    for (int v = 0; v < 32; v++) sweep_vals.push_back(v);
    for (int v = 65500; v < 65536; v++) sweep_vals.push_back(v);
    foreach (sweep_vals[x]) begin
      foreach (sweep_vals[y]) begin
        vld[1] = 1; opa[1] = 16'(sweep_vals[x]); opb[1] = 16'(sweep_vals[y]);
        step(); drain();
      end
    end

    // Random traffic with random backpressure
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          vld[i] = 1; opa[i] = rnd_op(); opb[i] = rnd_op();
        end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) vld[i] = 0;
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Shares the single 16-bit ripple `adder` (operands `a`/`b`, outputs `sum`/`c_out`) between several requesters. Operand pairs arrive on per-requester valid/ready channels and are granted round-robin. The granted operands are registered into the adder, and the block waits a fixed number of settle cycles to cover the adder's combinational delay. The result is then returned on one shared response channel tagged with the requester id. The block sits between the requester logic and the adder and is the only driver of the adder's inputs.

## Interface
- `NREQ`, 4 — number of requesters, 2..8
- `WIDTH`, 16 — operand/sum width; must match the `adder` instance
- `SETTLE`, 2 — clock cycles allowed for the adder to settle, ≥1
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — reset, synchronous, active-high
- `req_valid` in NREQ — requester i has an operand pair
- `req_ready` out NREQ — one-hot grant; handshake when `req_valid[i] & req_ready[i]`
- `req_a` in NREQ*WIDTH — operand a, requester i at bits [i*WIDTH +: WIDTH]
- `req_b` in NREQ*WIDTH — operand b, same packing
- `rsp_valid` out 1 — response available
- `rsp_ready` in 1 — consumer accepts the response
- `rsp_id` out clog2(NREQ) — index of the requester that issued the operation
- `rsp_sum` out WIDTH — result sum
- `rsp_c_out` out 1 — adder carry out

## Operation
- FSM states: IDLE, SETTLE, RESP.
- **IDLE**
  - Search `req_valid` starting at round-robin pointer `ptr`, ascending, wrapping at NREQ.
  - First hit g: `req_ready[g]`=1 combinationally in the same cycle.
  - On that clock edge, capture `req_a[g]`/`req_b[g]` into the operand registers, latch id g, load the settle counter with `SETTLE`, go to SETTLE.
  - If no request is valid, stay in IDLE.
- **SETTLE**
  - Counter decrements each cycle.
  - When it reaches 1, on that edge register adder `sum`/`c_out` into `rsp_sum`/`rsp_c_out` and go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - On `rsp_valid & rsp_ready`: set `ptr` = (g+1) mod NREQ, go to IDLE.
  - While `rsp_ready`=0: hold all response outputs stable and keep `req_ready` all-zero.
- `req_ready` is all-zero outside IDLE. Requests not granted stay pending; the arbiter never drops a valid request.
- Arithmetic: `{rsp_c_out, rsp_sum}` = a + b, zero-extended to WIDTH+1 bits. Without saturation, the sum wraps modulo 2^WIDTH.
- Adder operand registers hold their value from capture until the next grant. The adder inputs never change during SETTLE or RESP.
- Simultaneous valids: exactly one grant per IDLE cycle. Over any NREQ consecutive grants with all valids held, each requester receives exactly one grant.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_c_out`=0.
  - Operand registers 0, `ptr`=0, state IDLE.
- Latency: request handshake in cycle T, so `rsp_valid` is first high in cycle T+SETTLE+1.
- Throughput: with `rsp_ready` held high, a new grant is possible every SETTLE+2 cycles.
- Reset during SETTLE or RESP:
  - The in-flight operation is discarded and no response is produced.
  - The next cycle is IDLE with `ptr`=0.
- `req_valid` deasserting during SETTLE/RESP has no effect on the in-flight operation.

## Configuration
- Macro `ADDER_ARB_SAT_EN`.
- Defined: when the carry out is 1, `rsp_sum` = all-ones (saturating unsigned add). `rsp_c_out` still reports 1.
- Undefined: `rsp_sum` is the wrapped adder sum. No extra logic.

## Structure
- Package `adder_arb_pkg`:
  - State enum (IDLE/SETTLE/RESP).
  - Default `NREQ`/`WIDTH`/`SETTLE` constants.
  - Id width function (clog2).
- Sub-module: the existing `adder` instantiated once, with ports `.a`, `.b`, `.sum`, `.c_out`.
- Round-robin priority search is natural as one internal function; no separate module.

## Test plan
- Requester 0 sends 0x0001+0x0002, `rsp_ready`=1 → cycle T+3 (SETTLE=2): `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=0x0003, `rsp_c_out`=0.
- Requester 2 sends 0xFFFF+0x0001 → `rsp_sum`=0x0000, `rsp_c_out`=1. With `ADDER_ARB_SAT_EN`: `rsp_sum`=0xFFFF, `rsp_c_out`=1.
- All four requesters valid from reset with distinct operands, held high → `rsp_id` sequence 0,1,2,3,0, one response every 4 cycles.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`/`rsp_sum`/`rsp_id` stable and `req_ready`=0 throughout. Release → IDLE the next cycle.
- `rst` asserted in the second SETTLE cycle → next cycle all outputs 0, no response issued. The pending request is re-granted starting from id 0.
- Exhaustive sweep a,b ∈ {0..31, 65500..65535} through requester 1 → every `{rsp_c_out,rsp_sum}` equals a+b.
